// File: rtl/pc_sequencer.sv
// Next-PC controller for the ProgramCounter: arbitrates sequential, branch, jump, trap and hold
// sources, captures the EPC on trap entry and traps when the fetch handshake stalls too long.
module pc_sequencer #(
  parameter int unsigned ADDR_WIDTH_POW = 6,
  localparam int unsigned ADDR_WIDTH = 1 << ADDR_WIDTH_POW,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'('h100),
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  fetch_ready,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  trap_req,
  input  logic                  trap_ack,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  fetch_valid,
  output logic                  flush,
  output logic                  misaligned,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [1:0]            state_out
);

  localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_nxt;
  logic             flush_nxt;
  logic             mis_nxt;
  logic             tmo_nxt;
  logic             trap_entry;

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign state_out = state;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      tcnt       <= '0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      epc        <= '0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      flush      <= flush_nxt;
      misaligned <= mis_nxt;
      timeout    <= tmo_nxt;
      if (trap_entry) begin
        epc <= pc_in;
      end
    end
  end

  // Only the highest-priority active source is examined; a misaligned target from a
  // losing source never raises a trap.
  always_comb begin
    state_nxt   = state;
    pc_next     = RESET_VECTOR;
    fetch_valid = 1'b0;
    tcnt_nxt    = '0;
    flush_nxt   = 1'b0;
    mis_nxt     = 1'b0;
    tmo_nxt     = 1'b0;
    trap_entry  = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        fetch_valid = ~stall;
        if (trap_req) begin
          trap_entry = 1'b1;
        end else if (jump) begin
          if (is_misaligned(jump_target)) begin
            trap_entry = 1'b1;
            mis_nxt    = 1'b1;
          end else begin
            pc_next   = jump_target;
            flush_nxt = 1'b1;
          end
        end else if (branch_taken) begin
          if (is_misaligned(branch_target)) begin
            trap_entry = 1'b1;
            mis_nxt    = 1'b1;
          end else begin
            pc_next   = branch_target;
            flush_nxt = 1'b1;
          end
        end else if ((tcnt == CNT_MAX) && !fetch_ready) begin
          trap_entry = 1'b1;
          tmo_nxt    = 1'b1;
        end else if (stall || !fetch_ready) begin
          pc_next = pc_in;
          if (!stall) begin
            tcnt_nxt = sat_inc(tcnt);
          end
        end else begin
          pc_next = pc_in + ADDR_WIDTH'(4);
        end
        if (trap_entry) begin
          pc_next   = TRAP_VECTOR;
          flush_nxt = 1'b1;
          state_nxt = TRAP;
        end
      end
      TRAP: begin
        // The handler address is presented even on the ack cycle so it is fetched first.
        pc_next = TRAP_VECTOR;
        if (trap_ack) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences for timeout/wrap/reset-in-trap,
// then randomized stimulus against a rule-level reference model.
module tb_pc_sequencer;

  localparam logic [63:0] RESET_VEC = 64'h0;
  localparam logic [63:0] TRAP_VEC  = 64'h100;
  localparam int          FTO       = 16;

  logic        clk_in;
  logic        reset;
  logic [63:0] pc_in;
  logic        fetch_ready;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        jump;
  logic [63:0] jump_target;
  logic        trap_req;
  logic        trap_ack;
  logic [63:0] pc_next;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned;
  logic        timeout;
  logic [63:0] epc;
  logic [1:0]  state_out;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .ADDR_WIDTH_POW(6),
    .RESET_VECTOR(RESET_VEC),
    .TRAP_VECTOR(TRAP_VEC),
    .FETCH_TIMEOUT(FTO)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .pc_in(pc_in),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .trap_req(trap_req),
    .trap_ack(trap_ack),
    .pc_next(pc_next),
    .fetch_valid(fetch_valid),
    .flush(flush),
    .misaligned(misaligned),
    .timeout(timeout),
    .epc(epc),
    .state_out(state_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    logic        stall;
    logic        fr;
    logic        br;
    logic [63:0] bt;
    logic        jmp;
    logic [63:0] jt;
    logic        trq;
    logic        tack;
    logic [63:0] pc;
    logic [63:0] e_pc;
    logic        e_fv;
    logic        e_flush;
    logic        e_mis;
    logic        e_tmo;
    logic [1:0]  e_st;
    logic [63:0] e_epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic fr, input logic br, input logic [63:0] bt,
                             input logic jmp, input logic [63:0] jt, input logic trq, input logic tack,
                             input logic [63:0] pc, input logic [63:0] e_pc, input logic e_fv,
                             input logic e_flush, input logic e_mis, input logic e_tmo,
                             input logic [1:0] e_st, input logic [63:0] e_epc);
    vec_t r;
    r.stall = s; r.fr = fr; r.br = br; r.bt = bt; r.jmp = jmp; r.jt = jt; r.trq = trq;
    r.tack = tack; r.pc = pc; r.e_pc = e_pc; r.e_fv = e_fv; r.e_flush = e_flush;
    r.e_mis = e_mis; r.e_tmo = e_tmo; r.e_st = e_st; r.e_epc = e_epc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    stall = t.stall; fetch_ready = t.fr; branch_taken = t.br; branch_target = t.bt;
    jump = t.jmp; jump_target = t.jt; trap_req = t.trq; trap_ack = t.tack; pc_in = t.pc;
  endtask

  task automatic check_vec(input vec_t t, input string tag);
    chk({tag, " pc_next"}, pc_next, t.e_pc);
    chk({tag, " fetch_valid"}, 64'(fetch_valid), 64'(t.e_fv));
    chk({tag, " flush"}, 64'(flush), 64'(t.e_flush));
    chk({tag, " misaligned"}, 64'(misaligned), 64'(t.e_mis));
    chk({tag, " timeout"}, 64'(timeout), 64'(t.e_tmo));
    chk({tag, " state"}, 64'(state_out), 64'(t.e_st));
    chk({tag, " epc"}, epc, t.e_epc);
  endtask

  task automatic step(input vec_t t, input string tag);
    drive(t);
    @(negedge clk_in);
    check_vec(t, tag);
    @(posedge clk_in);
    #1;
  endtask

  // Reference model state (rule level, run-length timeout tracking)
  logic [1:0]  m_state;
  int          m_starve;
  logic [63:0] m_epc;
  logic [63:0] m_pc;
  logic        m_flush;
  logic        m_mis;
  logic        m_tmo;

  task automatic model_comb(output logic [63:0] npc, output logic fv, output logic to_trap,
                            output logic redir, output logic mis, output logic tmo);
    npc = RESET_VEC; fv = 1'b0; to_trap = 1'b0; redir = 1'b0; mis = 1'b0; tmo = 1'b0;
    if (m_state == 2'd2) begin
      npc = TRAP_VEC;
    end else if (m_state == 2'd1) begin
      fv = !stall;
      if (trap_req) to_trap = 1'b1;
      else if (jump) begin
        if (jump_target % 4 != 0) begin to_trap = 1'b1; mis = 1'b1; end
        else begin redir = 1'b1; npc = jump_target; end
      end else if (branch_taken) begin
        if (branch_target % 4 != 0) begin to_trap = 1'b1; mis = 1'b1; end
        else begin redir = 1'b1; npc = branch_target; end
      end else if (m_starve >= FTO - 1 && !fetch_ready) begin
        to_trap = 1'b1; tmo = 1'b1;
      end else if (stall || !fetch_ready) npc = pc_in;
      else npc = pc_in + 64'd4;
      if (to_trap) begin redir = 1'b1; npc = TRAP_VEC; end
    end
  endtask

  function automatic logic [63:0] rnd_tgt();
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  initial begin
    vec_t t;
    logic [63:0] e_npc;
    logic e_fv, to_trap, redir, mis, tmo, starve_phase;

    reset = 1'b1;
    drive(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_in); #1;
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
    reset = 1'b0;

    //       st fr br bt     j  jt      tq ta pc        e_pc      fv fl mi to st e_epc
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 0,        0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 0,        4,        1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 4,        8,        1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0,     0, 0,      0, 0, 8,        8,        0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0,     0, 0,      0, 0, 8,        8,        0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0,     0, 0,      0, 0, 8,        8,        0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 8,        'hC,      1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'hC,      'h10,     1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 1, 'h40,  0, 0,      0, 0, 'h10,     'h40,     0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h40,     'h44,     1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h44,     'h48,     1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 'h40,  1, 'h20,   0, 0, 'h48,     'h20,     1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h20,     'h24,     1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     1, 'h20,   1, 0, 'h24,     'h100,    1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h100,    'h100,    0, 1, 0, 0, 2, 'h24));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 1, 'h100,    'h100,    0, 0, 0, 0, 2, 'h24));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h100,    'h104,    1, 0, 0, 0, 1, 'h24));
    tbl.push_back(v(0, 1, 1, 'h42,  0, 0,      0, 0, 'h30,     'h100,    1, 0, 0, 0, 1, 'h24));
    tbl.push_back(v(1, 1, 1, 'h40,  1, 'h20,   1, 0, 'h100,    'h100,    0, 1, 1, 0, 2, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h100,    'h100,    0, 0, 0, 0, 2, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 1, 'h100,    'h100,    0, 0, 0, 0, 2, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h100,    'h104,    1, 0, 0, 0, 1, 'h30));
    tbl.push_back(v(0, 1, 1, 'h43,  1, 'h200,  0, 0, 'h104,    'h200,    1, 0, 0, 0, 1, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h200,    'h204,    1, 1, 0, 0, 1, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     1, 'h201,  0, 0, 'h204,    'h100,    1, 0, 0, 0, 1, 'h30));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 1, 'h100,    'h100,    0, 1, 1, 0, 2, 'h204));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,      0, 0, 'h100,    'h104,    1, 0, 0, 0, 1, 'h204));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,      0, 0, 'h104,    'h104,    1, 0, 0, 0, 1, 'h204));
    tbl.push_back(v(1, 1, 0, 0,     0, 0,      0, 0, 'h104,    'h104,    0, 0, 0, 0, 1, 'h204));

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Fetch starvation: the 16th consecutive not-ready cycle traps
    for (int i = 0; i < FTO; i++) begin
      step(v(0, 0, 0, 0, 0, 0, 0, 0, 'h50, (i == FTO - 1) ? TRAP_VEC : 64'h50, 1, 0, 0, 0, 1, 'h204),
           $sformatf("starve%0d", i));
    end
    step(v(0, 1, 0, 0, 0, 0, 0, 1, 'h100, 'h100, 0, 1, 0, 1, 2, 'h50), "tmo_trap");
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 0, 0, 1, 'h50), "wrap");
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 'h50), "after_wrap");
    step(v(0, 1, 0, 0, 0, 0, 1, 0, 'h60, 'h100, 1, 0, 0, 0, 1, 'h50), "trap_req");

    // Asynchronous reset in the middle of a trap
    t = v(0, 1, 0, 0, 0, 0, 0, 0, 'h100, 'h100, 0, 1, 0, 0, 2, 'h60);
    drive(t);
    @(negedge clk_in);
    check_vec(t, "in_trap");
    #1 reset = 1'b1;
    #1 check_vec(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "async_rst");
    @(posedge clk_in); #1;
    reset = 1'b0;
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reboot");
    step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0), "rerun");

    // Randomized run against the reference model
    reset = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    m_state = 2'd0; m_starve = 0; m_epc = '0; m_pc = RESET_VEC;
    m_flush = 1'b0; m_mis = 1'b0; m_tmo = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      starve_phase = ((i / 64) % 2) == 1;
      if (starve_phase) begin
        stall = ($urandom_range(0, 31) == 0);
        fetch_ready = ($urandom_range(0, 31) < 2);
        trap_req = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        fetch_ready = ($urandom_range(0, 7) != 0);
        trap_req = ($urandom_range(0, 15) == 0);
        jump = ($urandom_range(0, 7) == 0);
        branch_taken = ($urandom_range(0, 5) == 0);
      end
      jump_target = rnd_tgt();
      branch_target = rnd_tgt();
      trap_ack = ($urandom_range(0, 2) == 0);
      pc_in = ($urandom_range(0, 63) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4))
                                           : m_pc;
      model_comb(e_npc, e_fv, to_trap, redir, mis, tmo);
      @(negedge clk_in);
      check_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, e_npc, e_fv, m_flush, m_mis, m_tmo, m_state, m_epc),
                $sformatf("rnd%0d", i));
      m_flush = redir; m_mis = mis; m_tmo = tmo;
      if (to_trap) m_epc = pc_in;
      if (m_state == 2'd1 && !redir && !stall && !fetch_ready) m_starve++;
      else m_starve = 0;
      case (m_state)
        2'd0: m_state = 2'd1;
        2'd1: if (to_trap) m_state = 2'd2;
        default: if (trap_ack) m_state = 2'd1;
      endcase
      m_pc = e_npc;
      @(posedge clk_in); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
